// File: rtl/ysyx_22040386_ifid_buffer.sv
// ============================================================================
//  Module   : ysyx_22040386_ifid_buffer
//  Purpose  : IF->ID decoupling FIFO of {pc, inst} pairs with single-cycle flush.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ysyx_22040386_ifid_buffer #(
    parameter int              DEPTH  = 2,
    parameter int              PC_W   = 64,
    parameter int              INST_W = 32,
    parameter logic [PC_W-1:0] RST_PC = 64'h0000_0000_8000_0000
) (
    input  logic                    i_IB_clk,
    input  logic                    i_IB_rst,
    input  logic                    i_IB_in_valid,
    output logic                    o_IB_in_ready,
    input  logic [PC_W-1:0]         i_IB_pc,
    input  logic [INST_W-1:0]       i_IB_inst,
    input  logic                    i_IB_flush,
    output logic                    o_IB_out_valid,
    input  logic                    i_IB_out_ready,
    output logic [PC_W-1:0]         o_IB_pc,
    output logic [INST_W-1:0]       o_IB_inst,
    output logic [$clog2(DEPTH):0]  o_IB_count
);

    localparam int                  c_PTR_W = $clog2(DEPTH);
    localparam int                  c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PONE  = c_PTR_W'(1);
    localparam logic [INST_W-1:0]   c_NOP   = INST_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]   w_rd_ptr_nxt;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   w_count_nxt;
    logic [PC_W-1:0]      r_pc_mem   [DEPTH];
    logic [INST_W-1:0]    r_inst_mem [DEPTH];
    logic                 w_push;
    logic                 w_pop;

    // Handshake outputs depend only on registered state, never on i_IB_out_ready.
    assign o_IB_in_ready  = (r_state != S_FULL);
    assign o_IB_out_valid = (r_state != S_EMPTY) & ~i_IB_flush;
    assign w_push         = i_IB_in_valid & o_IB_in_ready & ~i_IB_flush;
    assign w_pop          = o_IB_out_valid & i_IB_out_ready;

    assign o_IB_pc    = (r_state == S_EMPTY) ? RST_PC : r_pc_mem[r_rd_ptr];
    assign o_IB_inst  = (r_state == S_EMPTY) ? c_NOP  : r_inst_mem[r_rd_ptr];
    assign o_IB_count = r_count;

    always_ff @(posedge i_IB_clk or posedge i_IB_rst) begin
        if (i_IB_rst) begin
            r_state  <= S_EMPTY;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    // Payload storage is never cleared; occupancy alone decides what is live.
    always_ff @(posedge i_IB_clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= i_IB_pc;
            r_inst_mem[r_wr_ptr] <= i_IB_inst;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (i_IB_flush) begin
            w_state_nxt  = S_EMPTY;
            w_count_nxt  = '0;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + c_PONE;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + c_PONE;
            end
            if (w_push && !w_pop) begin
                w_count_nxt = r_count + c_ONE;
            end else if (w_pop && !w_push) begin
                w_count_nxt = r_count - c_ONE;
            end
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = S_PARTIAL;
                    end
                end
                S_PARTIAL: begin
                    if (w_push && !w_pop && (r_count + c_ONE == c_DEPTH)) begin
                        w_state_nxt = S_FULL;
                    end else if (w_pop && !w_push && (r_count == c_ONE)) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        w_state_nxt = S_PARTIAL;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040386_ifid_buffer.sv
// ============================================================================
//  Module   : tb_ysyx_22040386_ifid_buffer
//  Purpose  : Self-checking bench: vector table, hand sequences, queue scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ysyx_22040386_ifid_buffer;

    localparam int          c_DEPTH  = 2;
    localparam logic [63:0] c_RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] c_NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] pc_in;
    logic [31:0] inst_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] pc_out;
    logic [31:0] inst_out;
    logic [1:0]  count;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic [63:0] pc_next;

    typedef struct {
        logic        iv;
        logic [63:0] pc;
        logic        fl;
        logic        ordy;
        logic        ev;
        logic        er;
        logic [1:0]  ec;
        logic [63:0] epc;
        logic [31:0] einst;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } pair_t;

    vec_t  vt [13];
    pair_t sb [$];

    ysyx_22040386_ifid_buffer dut (
        .i_IB_clk       (clk),
        .i_IB_rst       (rst),
        .i_IB_in_valid  (in_valid),
        .o_IB_in_ready  (in_ready),
        .i_IB_pc        (pc_in),
        .i_IB_inst      (inst_in),
        .i_IB_flush     (flush),
        .o_IB_out_valid (out_valid),
        .i_IB_out_ready (out_ready),
        .o_IB_pc        (pc_out),
        .o_IB_inst      (inst_out),
        .o_IB_count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hA5A5_0003;
    endfunction

    function automatic vec_t mk(input logic iv, input logic [63:0] pc, input logic fl,
                                input logic ordy, input logic ev, input logic er,
                                input logic [1:0] ec, input logic [63:0] epc, input logic hd);
        vec_t v;
        v.iv = iv; v.pc = pc; v.fl = fl; v.ordy = ordy;
        v.ev = ev; v.er = er; v.ec = ec;
        v.epc   = hd ? epc : c_RST_PC;
        v.einst = hd ? inst_of(epc) : c_NOP;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One cycle against the queue model; inputs change 1ns after the edge.
    task automatic tick(input logic iv, input logic fl, input logic ordy);
        logic  e_ready;
        logic  e_valid;
        pair_t p;
        in_valid  = iv;
        pc_in     = pc_next;
        inst_in   = inst_of(pc_next);
        flush     = fl;
        out_ready = ordy;
        #1;
        e_ready = (sb.size() < c_DEPTH);
        e_valid = (sb.size() != 0) && !fl;
        chk("in_ready",  64'(in_ready),  64'(e_ready));
        chk("out_valid", 64'(out_valid), 64'(e_valid));
        chk("count",     64'(count),     64'(sb.size()));
        if (sb.size() != 0) begin
            chk("head_pc",   pc_out,          sb[0].pc);
            chk("head_inst", 64'(inst_out),   64'(sb[0].inst));
        end else begin
            chk("empty_pc",   pc_out,        c_RST_PC);
            chk("empty_inst", 64'(inst_out), 64'(c_NOP));
        end
        if (fl) begin
            sb.delete();
            pc_next = pc_next + 64'h100;
        end else begin
            if (e_valid && ordy) begin
                void'(sb.pop_front());
                pops++;
            end
            if (iv && e_ready) begin
                p.pc   = pc_next;
                p.inst = inst_of(pc_next);
                sb.push_back(p);
                pc_next = pc_next + 64'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // fill/drain with held third push, then flush with a full buffer
        vt[0]  = mk(1, 64'h8000_0000, 0, 0, 0, 1, 2'd0, 64'h0,          0);
        vt[1]  = mk(1, 64'h8000_0004, 0, 0, 1, 1, 2'd1, 64'h8000_0000, 1);
        vt[2]  = mk(1, 64'h8000_0008, 0, 0, 1, 0, 2'd2, 64'h8000_0000, 1);
        vt[3]  = mk(1, 64'h8000_0008, 0, 1, 1, 0, 2'd2, 64'h8000_0000, 1);
        vt[4]  = mk(1, 64'h8000_0008, 0, 1, 1, 1, 2'd1, 64'h8000_0004, 1);
        vt[5]  = mk(0, 64'h0,         0, 1, 1, 1, 2'd1, 64'h8000_0008, 1);
        vt[6]  = mk(0, 64'h0,         0, 0, 0, 1, 2'd0, 64'h0,          0);
        vt[7]  = mk(1, 64'h8000_0100, 0, 0, 0, 1, 2'd0, 64'h0,          0);
        vt[8]  = mk(1, 64'h8000_0104, 0, 0, 1, 1, 2'd1, 64'h8000_0100, 1);
        vt[9]  = mk(1, 64'h8000_0010, 1, 1, 0, 0, 2'd2, 64'h8000_0100, 1);
        vt[10] = mk(1, 64'h8000_1000, 0, 0, 0, 1, 2'd0, 64'h0,          0);
        vt[11] = mk(0, 64'h0,         0, 1, 1, 1, 2'd1, 64'h8000_1000, 1);
        vt[12] = mk(0, 64'h0,         0, 0, 0, 1, 2'd0, 64'h0,          0);

        rst = 1'b1; in_valid = 1'b0; pc_in = '0; inst_in = '0; flush = 1'b0; out_ready = 1'b0;
        pc_next = 64'h8000_0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready),  64'd1);
        chk("rst_count", 64'(count),     64'd0);
        chk("rst_pc",    pc_out,         c_RST_PC);
        chk("rst_inst",  64'(inst_out),  64'(c_NOP));
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            in_valid  = vt[i].iv;
            pc_in     = vt[i].pc;
            inst_in   = inst_of(vt[i].pc);
            flush     = vt[i].fl;
            out_ready = vt[i].ordy;
            #1;
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vt[i].ev));
            chk($sformatf("v%0d_ready", i), 64'(in_ready),  64'(vt[i].er));
            chk($sformatf("v%0d_count", i), 64'(count),     64'(vt[i].ec));
            chk($sformatf("v%0d_pc", i),    pc_out,         vt[i].epc);
            chk($sformatf("v%0d_inst", i),  64'(inst_out),  64'(vt[i].einst));
            @(posedge clk);
            #1;
        end

        // asynchronous reset mid-run with two entries queued
        sb.delete();
        pc_next = 64'h9000_0000;
        tick(1, 0, 0);
        tick(1, 0, 0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready),  64'd1);
        chk("mid_rst_count", 64'(count),     64'd0);
        chk("mid_rst_pc",    pc_out,         c_RST_PC);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // streaming: one push and one pop per cycle once primed
        pc_next = 64'h8000_2000;
        pops = 0;
        for (int i = 0; i < 20; i++) tick(1, 0, 1);
        chk("stream_pops", 64'(pops), 64'd19);

        // flush while full with ID ready
        tick(1, 0, 0);
        tick(0, 1, 1);
        chk("fullflush_ready", 64'(in_ready),  64'd1);
        chk("fullflush_count", 64'(count),     64'd0);
        tick(0, 0, 1);

        // random backpressure with occasional redirects
        for (int i = 0; i < 1000; i++) begin
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
